sdram_state_ctrl: RTL and testbench
===================================

Name: sdram_state_ctrl

Overview:
- Timing and state sequencer for the SDRAM controller.
- Runs the power-up and initialisation sequence, then arbitrates between auto-refresh, burst-write and burst-read requests.
- Drives init_state, work_state, cnt_clk and sdram_rd_wr to the downstream command encoder, which turns them into SDRAM pin commands.
- Returns data-phase acks and init-done to the upstream FIFO controller.

Parameters:
- POWERUP_CYC, 20000: power-up wait in clk cycles (200 us at 100 MHz).
- REF_PERIOD, 781: clk cycles between refresh requests (7.8 us).
- INIT_AR_NUM, 8: auto-refresh commands issued during init.
- TRP_CLK, 4: precharge period in cycles.
- TRC_CLK, 6: auto-refresh period in cycles.
- TRSC_CLK, 6: mode-register-set wait in cycles.
- TRCD_CLK, 2: active-to-read/write delay in cycles.
- TCL_CLK, 3: CAS latency in cycles.
- TWR_CLK, 2: write recovery in cycles.

Ports:
- clk  in  1  controller clock
- rst_n  in  1  reset
- sdram_wr_req  in  1  burst write request, level, held until ack
- sdram_rd_req  in  1  burst read request, level, held until ack
- sdram_wr_burst  in  10  write burst length, 1..256
- sdram_rd_burst  in  10  read burst length, 1..256
- sdram_init_done  out  1  high once init_state = I_DONE
- sdram_wr_ack  out  1  write data phase, one cycle per word
- sdram_rd_ack  out  1  read data phase, one cycle per word
- init_state  out  5  init FSM state
- work_state  out  4  work FSM state
- cnt_clk  out  10  cycles elapsed in current state
- sdram_rd_wr  out  1  1 = read selected, 0 = write selected

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk. All state, counters and flags update on posedge clk.
- Reset values: init_state = I_NOP, work_state = W_IDLE, cnt_clk = 0, sdram_rd_wr = 1, acks = 0, init_done = 0, refresh flag = 0, all counters = 0.
- Init state encodings:
  - I_NOP=0, I_PRE=1, I_TRP=2, I_AR=3, I_TRF=4, I_MRS=5, I_TRSC=6, I_DONE=7.
- Work state encodings:
  - W_IDLE=0, W_ACTIVE=1, W_TRCD=2, W_READ=3, W_CL=4, W_RD=5, W_WRITE=6, W_WD=7.
  - W_TWR=8, W_PRE=9, W_TRP=10, W_AR=11, W_TRFC=12.
- cnt_clk:
  - Increments every cycle.
  - Clears to 0 on the cycle any state (init or work) changes, so the first cycle in a state has cnt_clk = 0.
  - Saturates at 1023.
- Init FSM:
  - Power-up counter runs from reset. I_NOP -> I_PRE when it reaches POWERUP_CYC-1.
  - I_PRE (1 cycle) -> I_TRP; leave when cnt_clk = TRP_CLK-1.
  - -> I_AR (1 cycle) -> I_TRF; leave when cnt_clk = TRC_CLK-1.
  - Init AR counter increments on each I_AR. From I_TRF, return to I_AR until INIT_AR_NUM refreshes have been issued, then go to I_MRS.
  - I_MRS (1 cycle) -> I_TRSC; leave when cnt_clk = TRSC_CLK-1.
  - -> I_DONE, terminal until reset.
  - work_state is held at W_IDLE until I_DONE.
- Refresh timer:
  - Counts only in I_DONE.
  - At REF_PERIOD-1, sets the refresh flag and wraps to 0.
  - Flag clears on entry to W_AR.
- W_IDLE arbitration, in priority order:
  - Refresh flag -> W_AR.
  - Else wr_req -> W_ACTIVE with sdram_rd_wr <= 0.
  - Else rd_req -> W_ACTIVE with sdram_rd_wr <= 1.
  - sdram_rd_wr is held through the whole transaction.
- Work transitions:
  - W_ACTIVE (1 cycle) -> W_TRCD; leave when cnt_clk = TRCD_CLK-1.
  - From W_TRCD: to W_WRITE if sdram_rd_wr = 0, else W_READ.
  - Write path: W_WRITE (1 cycle) -> W_WD; leave when cnt_clk = sdram_wr_burst-1 -> W_TWR; leave when cnt_clk = TWR_CLK-1 -> W_PRE.
  - Read path: W_READ (1 cycle) -> W_CL; leave when cnt_clk = TCL_CLK-1 -> W_RD; leave when cnt_clk = sdram_rd_burst-1 -> W_PRE.
  - Precharge: W_PRE (1 cycle) -> W_TRP; leave when cnt_clk = TRP_CLK-1 -> W_IDLE.
  - Refresh: W_AR (1 cycle) -> W_TRFC; leave when cnt_clk = TRC_CLK-1 -> W_IDLE.
- Acks (combinational from registered state):
  - sdram_wr_ack = (work_state = W_WD).
  - sdram_rd_ack = (work_state = W_RD).
  - Each is high for exactly burst-length cycles.
- Burst lengths are sampled on every cycle; upstream holds them stable from request until the ack falls.
- A refresh-flag set mid-burst does not interrupt the burst. Refresh is taken at the next W_IDLE, before any pending request.
- Back-to-back requests: at least one W_IDLE cycle between transactions.
- rst_n asserted mid-operation returns everything to reset values immediately, and init restarts from I_NOP.

Test Plan:
- Reset, POWERUP_CYC=20 -> init_state sequence 0,1,2x4,(3,4x6)x8,5,6x6,7; init_done rises on the first I_DONE cycle.
- wr_req with wr_burst=8 -> W_ACTIVE, W_TRCDx2, W_WRITE, W_WDx8 with wr_ack high for 8 cycles, W_TWRx2, W_PRE, W_TRPx4, W_IDLE; sdram_rd_wr=0 throughout.
- rd_req with rd_burst=4 -> W_ACTIVE, W_TRCDx2, W_READ, W_CLx3, W_RDx4 with rd_ack high for 4 cycles, then W_PRE; sdram_rd_wr=1.
- wr_req and rd_req both high in W_IDLE -> write served first, read follows after return to W_IDLE.
- REF_PERIOD=50 during a 256-word write -> burst completes uninterrupted, then W_AR, W_TRFCx6 occur before the pending read.
- rst_n pulsed low during W_WD -> outputs return to reset values on the same edge; no ack afterwards until init completes again.

Source files
------------

// File: rtl/sdram_state_ctrl_if.sv
// Upstream/downstream signal bundle of the SDRAM state sequencer.
// The controller uses the slave modport. The FIFO side and the command encoder use master.
interface sdram_state_ctrl_if;
  logic       sdram_wr_req;
  logic       sdram_rd_req;
  logic [9:0] sdram_wr_burst;
  logic [9:0] sdram_rd_burst;
  logic       sdram_init_done;
  logic       sdram_wr_ack;
  logic       sdram_rd_ack;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;
  logic       sdram_rd_wr;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
    input  sdram_init_done, sdram_wr_ack, sdram_rd_ack,
    input  init_state, work_state, cnt_clk, sdram_rd_wr
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_wr_burst, sdram_rd_burst,
    output sdram_init_done, sdram_wr_ack, sdram_rd_ack,
    output init_state, work_state, cnt_clk, sdram_rd_wr
  );
endinterface

// File: rtl/sdram_state_ctrl.sv
// SDRAM timing and state sequencer. It runs power-up and init first.
// After init it arbitrates refresh, burst-write and burst-read.
module sdram_state_ctrl #(
  parameter int POWERUP_CYC = 20000,
  parameter int REF_PERIOD  = 781,
  parameter int INIT_AR_NUM = 8,
  parameter int TRP_CLK     = 4,
  parameter int TRC_CLK     = 6,
  parameter int TRSC_CLK    = 6,
  parameter int TRCD_CLK    = 2,
  parameter int TCL_CLK     = 3,
  parameter int TWR_CLK     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_state_ctrl_if.slave   bus
);

  localparam logic [4:0] I_NOP = 5'd0, I_PRE = 5'd1, I_TRP = 5'd2, I_AR   = 5'd3,
                         I_TRF = 5'd4, I_MRS = 5'd5, I_TRSC = 5'd6, I_DONE = 5'd7;

  localparam logic [3:0] W_IDLE = 4'd0,  W_ACTIVE = 4'd1, W_TRCD = 4'd2,  W_READ = 4'd3,
                         W_CL   = 4'd4,  W_RD     = 4'd5, W_WRITE = 4'd6, W_WD   = 4'd7,
                         W_TWR  = 4'd8,  W_PRE    = 4'd9, W_TRP  = 4'd10, W_AR   = 4'd11,
                         W_TRFC = 4'd12;

  localparam int PWR_W = $clog2(POWERUP_CYC + 1);
  localparam int REF_W = $clog2(REF_PERIOD + 1);
  localparam int AR_W  = $clog2(INIT_AR_NUM + 1);

  localparam logic [PWR_W-1:0] PWR_END  = PWR_W'(POWERUP_CYC - 1);
  localparam logic [REF_W-1:0] REF_END  = REF_W'(REF_PERIOD - 1);
  localparam logic [AR_W-1:0]  AR_END   = AR_W'(INIT_AR_NUM);
  localparam logic [9:0]       TRP_END  = 10'(TRP_CLK - 1);
  localparam logic [9:0]       TRC_END  = 10'(TRC_CLK - 1);
  localparam logic [9:0]       TRSC_END = 10'(TRSC_CLK - 1);
  localparam logic [9:0]       TRCD_END = 10'(TRCD_CLK - 1);
  localparam logic [9:0]       TCL_END  = 10'(TCL_CLK - 1);
  localparam logic [9:0]       TWR_END  = 10'(TWR_CLK - 1);

  logic [4:0]       init_state, init_next;
  logic [3:0]       work_state, work_next;
  logic [9:0]       cnt_clk;
  logic             rd_wr, rd_wr_next;
  logic [PWR_W-1:0] pwr_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic [AR_W-1:0]  ar_cnt;
  logic             ref_flag;
  logic             init_done;
  logic             state_chg;

  assign init_done = (init_state == I_DONE);
  assign state_chg = (init_next != init_state) || (work_next != work_state);

  // NOTE: every variable gets a default before the case, so no path can leave it unassigned and infer a latch.
  always_comb begin
    init_next = init_state;
    case (init_state)
      I_NOP:   if (pwr_cnt == PWR_END)   init_next = I_PRE;
      I_PRE:                             init_next = I_TRP;
      I_TRP:   if (cnt_clk == TRP_END)   init_next = I_AR;
      I_AR:                              init_next = I_TRF;
      I_TRF:   if (cnt_clk == TRC_END)   init_next = (ar_cnt == AR_END) ? I_MRS : I_AR;
      I_MRS:                             init_next = I_TRSC;
      I_TRSC:  if (cnt_clk == TRSC_END)  init_next = I_DONE;
      I_DONE:                            init_next = I_DONE;
      default:                           init_next = I_NOP;
    endcase
  end

  // The work FSM stays parked in W_IDLE until init has completed.
  always_comb begin
    work_next  = work_state;
    rd_wr_next = rd_wr;
    case (work_state)
      W_IDLE:
        if (init_done) begin
          if (ref_flag) begin
            work_next = W_AR;
          end else if (bus.sdram_wr_req) begin
            work_next  = W_ACTIVE;
            rd_wr_next = 1'b0;
          end else if (bus.sdram_rd_req) begin
            work_next  = W_ACTIVE;
            rd_wr_next = 1'b1;
          end
        end
      W_ACTIVE:                                            work_next = W_TRCD;
      W_TRCD:  if (cnt_clk == TRCD_END)                    work_next = rd_wr ? W_READ : W_WRITE;
      W_READ:                                              work_next = W_CL;
      W_CL:    if (cnt_clk == TCL_END)                     work_next = W_RD;
      W_RD:    if (cnt_clk == bus.sdram_rd_burst - 10'd1)  work_next = W_PRE;
      W_WRITE:                                             work_next = W_WD;
      W_WD:    if (cnt_clk == bus.sdram_wr_burst - 10'd1)  work_next = W_TWR;
      W_TWR:   if (cnt_clk == TWR_END)                     work_next = W_PRE;
      W_PRE:                                               work_next = W_TRP;
      W_TRP:   if (cnt_clk == TRP_END)                     work_next = W_IDLE;
      W_AR:                                                work_next = W_TRFC;
      W_TRFC:  if (cnt_clk == TRC_END)                     work_next = W_IDLE;
      default:                                             work_next = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so each register reads the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state <= I_NOP;
      work_state <= W_IDLE;
      cnt_clk    <= '0;
      rd_wr      <= 1'b1;
      pwr_cnt    <= '0;
      ref_cnt    <= '0;
      ar_cnt     <= '0;
      ref_flag   <= 1'b0;
    end else begin
      init_state <= init_next;
      work_state <= work_next;
      rd_wr      <= rd_wr_next;

      if (state_chg)               cnt_clk <= '0;
      else if (cnt_clk != 10'h3FF) cnt_clk <= cnt_clk + 10'd1;

      if (init_state == I_NOP && pwr_cnt != PWR_END) pwr_cnt <= pwr_cnt + PWR_W'(1);
      if (init_state == I_AR)                        ar_cnt  <= ar_cnt + AR_W'(1);

      if (init_done) ref_cnt <= (ref_cnt == REF_END) ? '0 : ref_cnt + REF_W'(1);

      // A new refresh tick wins over the clear, so a tick is never dropped.
      if (init_done && ref_cnt == REF_END)                 ref_flag <= 1'b1;
      else if (work_state == W_IDLE && work_next == W_AR)  ref_flag <= 1'b0;
    end
  end

  assign bus.sdram_init_done = init_done;
  assign bus.sdram_wr_ack    = (work_state == W_WD);
  assign bus.sdram_rd_ack    = (work_state == W_RD);
  assign bus.init_state      = init_state;
  assign bus.work_state      = work_state;
  assign bus.cnt_clk         = cnt_clk;
  assign bus.sdram_rd_wr     = rd_wr;

endmodule

// File: tb/tb_sdram_state_ctrl.sv
// Randomised bench for sdram_state_ctrl. The reference model is a segment schedule:
// each transaction expands into a queue of (state, duration) pairs.
module tb_sdram_state_ctrl;

  localparam int POWERUP_CYC = 20;
  localparam int REF_PERIOD  = 50;
  localparam int INIT_AR_NUM = 8;
  localparam int TRP_CLK     = 4;
  localparam int TRC_CLK     = 6;
  localparam int TRSC_CLK    = 6;
  localparam int TRCD_CLK    = 2;
  localparam int TCL_CLK     = 3;
  localparam int TWR_CLK     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdram_state_ctrl_if bus ();

  sdram_state_ctrl #(
    .POWERUP_CYC(POWERUP_CYC), .REF_PERIOD(REF_PERIOD), .INIT_AR_NUM(INIT_AR_NUM),
    .TRP_CLK(TRP_CLK), .TRC_CLK(TRC_CLK), .TRSC_CLK(TRSC_CLK),
    .TRCD_CLK(TRCD_CLK), .TCL_CLK(TCL_CLK), .TWR_CLK(TWR_CLK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: the current state, the cycles left in it, and the queued follow-on states.
  typedef struct { int st; int len; } seg_t;
  seg_t init_q[$];
  seg_t work_q[$];
  int   m_init, m_work, init_left, work_left, m_age, m_done_cyc;
  bit   m_rd_wr, m_flag;

  function automatic void add_init(input int st, input int len);
    seg_t s;
    s.st = st; s.len = len;
    init_q.push_back(s);
  endfunction

  function automatic void add_work(input int st, input int len);
    seg_t s;
    s.st = st; s.len = len;
    work_q.push_back(s);
  endfunction

  task automatic model_reset();
    init_q.delete();
    work_q.delete();
    add_init(1, 1);
    add_init(2, TRP_CLK);
    for (int i = 0; i < INIT_AR_NUM; i++) begin
      add_init(3, 1);
      add_init(4, TRC_CLK);
    end
    add_init(5, 1);
    add_init(6, TRSC_CLK);
    add_init(7, 0);
    m_init = 0; init_left = POWERUP_CYC;
    m_work = 0; work_left = 0;
    m_age = 0; m_done_cyc = 0;
    m_rd_wr = 1'b1; m_flag = 1'b0;
  endtask

  task automatic model_step();
    int   p_init = m_init;
    int   p_work = m_work;
    bit   set_evt = 1'b0;
    bit   take_ar = 1'b0;
    seg_t s;
    if (p_init == 7) begin
      if (m_done_cyc % REF_PERIOD == REF_PERIOD - 1) set_evt = 1'b1;
      m_done_cyc++;
      if (p_work == 0) begin
        if (m_flag) begin
          take_ar = 1'b1;
          m_work = 11; work_left = 1;
          add_work(12, TRC_CLK);
        end else if (bus.sdram_wr_req) begin
          m_rd_wr = 1'b0;
          m_work = 1; work_left = 1;
          add_work(2, TRCD_CLK); add_work(6, 1); add_work(7, int'(bus.sdram_wr_burst));
          add_work(8, TWR_CLK);  add_work(9, 1); add_work(10, TRP_CLK);
        end else if (bus.sdram_rd_req) begin
          m_rd_wr = 1'b1;
          m_work = 1; work_left = 1;
          add_work(2, TRCD_CLK); add_work(3, 1); add_work(4, TCL_CLK);
          add_work(5, int'(bus.sdram_rd_burst)); add_work(9, 1); add_work(10, TRP_CLK);
        end
      end else begin
        work_left--;
        if (work_left == 0) begin
          if (work_q.size() == 0) begin
            m_work = 0;
          end else begin
            s = work_q.pop_front();
            m_work = s.st; work_left = s.len;
          end
        end
      end
    end else begin
      init_left--;
      if (init_left == 0) begin
        s = init_q.pop_front();
        m_init = s.st; init_left = s.len;
      end
    end
    if (set_evt)      m_flag = 1'b1;
    else if (take_ar) m_flag = 1'b0;
    if (m_init != p_init || m_work != p_work) m_age = 0;
    else if (m_age < 1023)                    m_age++;
  endtask

  task automatic compare_all();
    check("init_state", int'(bus.init_state),      m_init);
    check("work_state", int'(bus.work_state),      m_work);
    check("cnt_clk",    int'(bus.cnt_clk),         m_age);
    check("rd_wr",      int'(bus.sdram_rd_wr),     int'(m_rd_wr));
    check("wr_ack",     int'(bus.sdram_wr_ack),    int'(m_work == 7));
    check("rd_ack",     int'(bus.sdram_rd_ack),    int'(m_work == 5));
    check("init_done",  int'(bus.sdram_init_done), int'(m_init == 7));
  endtask

  // Upstream side: requests are held until their ack, and each ack run must last exactly one burst.
  int wr_run = 0;
  int rd_run = 0;

  function automatic logic [9:0] pick_burst();
    case ($urandom_range(0, 3))
      0:       return 10'd1;
      1:       return 10'd256;
      default: return 10'($urandom_range(1, 16));
    endcase
  endfunction

  task automatic upstream(input int wr_pct, input int rd_pct);
    if (bus.sdram_wr_ack) wr_run++;
    else if (wr_run > 0) begin
      check("wr_ack_len", wr_run, int'(bus.sdram_wr_burst));
      wr_run = 0;
    end
    if (bus.sdram_rd_ack) rd_run++;
    else if (rd_run > 0) begin
      check("rd_ack_len", rd_run, int'(bus.sdram_rd_burst));
      rd_run = 0;
    end
    if (bus.sdram_wr_req && bus.sdram_wr_ack) bus.sdram_wr_req = 1'b0;
    else if (!bus.sdram_wr_req && !bus.sdram_wr_ack && $urandom_range(0, 99) < wr_pct) begin
      bus.sdram_wr_burst = pick_burst();
      bus.sdram_wr_req   = 1'b1;
    end
    if (bus.sdram_rd_req && bus.sdram_rd_ack) bus.sdram_rd_req = 1'b0;
    else if (!bus.sdram_rd_req && !bus.sdram_rd_ack && $urandom_range(0, 99) < rd_pct) begin
      bus.sdram_rd_burst = pick_burst();
      bus.sdram_rd_req   = 1'b1;
    end
  endtask

  task automatic run_cycles(input int n, input int wr_pct, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_step();
      #1 compare_all();
      @(negedge clk);
      upstream(wr_pct, rd_pct);
    end
  endtask

  initial begin
    bit seen_ack;
    bus.sdram_wr_req   = 1'b0;
    bus.sdram_rd_req   = 1'b0;
    bus.sdram_wr_burst = 10'd8;
    bus.sdram_rd_burst = 10'd4;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // The full init sequence with no traffic.
    run_cycles(120, 0, 0);

    // Write and read requested together: the write goes first, then the read.
    bus.sdram_wr_burst = 10'd8;
    bus.sdram_rd_burst = 10'd4;
    bus.sdram_wr_req   = 1'b1;
    bus.sdram_rd_req   = 1'b1;
    run_cycles(150, 0, 0);

    // Random traffic, with refresh ticks landing inside bursts.
    run_cycles(3000, 30, 30);
    run_cycles(700, 0, 0);

    // A long write, interrupted by reset during its data phase.
    bus.sdram_wr_burst = 10'd200;
    bus.sdram_wr_req   = 1'b1;
    seen_ack = 1'b0;
    for (int k = 0; k < 600 && !seen_ack; k++) begin
      run_cycles(1, 0, 0);
      seen_ack = bus.sdram_wr_ack;
    end
    check("wr_ack_seen", int'(seen_ack), 1);
    run_cycles(5, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_init_state", int'(bus.init_state),      0);
    check("rst_work_state", int'(bus.work_state),      0);
    check("rst_cnt_clk",    int'(bus.cnt_clk),         0);
    check("rst_rd_wr",      int'(bus.sdram_rd_wr),     1);
    check("rst_wr_ack",     int'(bus.sdram_wr_ack),    0);
    check("rst_init_done",  int'(bus.sdram_init_done), 0);
    model_reset();
    bus.sdram_wr_req = 1'b0;
    wr_run = 0;
    rd_run = 0;
    run_cycles(2, 0, 0);
    rst_n = 1'b1;
    run_cycles(150, 0, 0);
    run_cycles(1000, 30, 30);
    run_cycles(700, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
